alu_result_buffer: RTL and testbench



---
 rtl/alu_result_buffer_if.sv | 32 +++
 rtl/alu_result_buffer.sv | 158 +++++++++++++++
 tb/tb_alu_result_buffer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_result_buffer_if.sv
// Handshake and status bundle between an ALU result producer, the result buffer and its consumer.
interface alu_result_buffer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OPW   = 3,
    parameter int unsigned CNTW  = 16
);
    localparam int unsigned LVLW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OPW-1:0]   out_op;
    logic             out_zero;
    logic             out_neg;
    logic [LVLW-1:0]  level;
    logic [CNTW-1:0]  done_cnt;

    modport master (
        output in_valid, in_result, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, level, done_cnt
    );

    modport slave (
        input  in_valid, in_result, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_neg, level, done_cnt
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Registered FIFO stage behind the combinational ALU logic units: stores result, op tag and
// zero/negative flags, presents the head over valid/ready and counts popped results.
module alu_result_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned OPW   = 3,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_buffer_if.slave   bus
);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned LVLW = PTRW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_e;

    state_e           state_q, state_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]  level_q, level_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] mem_res_q  [DEPTH];
    logic [WIDTH-1:0] mem_res_d  [DEPTH];
    logic [OPW-1:0]   mem_op_q   [DEPTH];
    logic [OPW-1:0]   mem_op_d   [DEPTH];
    logic             mem_zero_q [DEPTH];
    logic             mem_zero_d [DEPTH];
    logic             mem_neg_q  [DEPTH];
    logic             mem_neg_d  [DEPTH];

    logic [WIDTH-1:0] head_res_q, head_res_d;
    logic [OPW-1:0]   head_op_q, head_op_d;
    logic             head_zero_q, head_zero_d;
    logic             head_neg_q, head_neg_d;

    logic push;
    logic pop;

    // Handshakes use only registered ready/valid, so out_ready never reaches in_ready.
    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    // Occupancy FSM, pointers, storage and next head entry.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        mem_res_d   = mem_res_q;
        mem_op_d    = mem_op_q;
        mem_zero_d  = mem_zero_q;
        mem_neg_d   = mem_neg_q;

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    level_d = LVLW'(1);
                    state_d = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop) begin
                    level_d = level_q + LVLW'(1);
                    if (level_d == LVLW'(DEPTH)) state_d = ST_FULL;
                end else if (pop && !push) begin
                    level_d = level_q - LVLW'(1);
                    if (level_d == LVLW'(0)) state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    level_d = level_q - LVLW'(1);
                    state_d = ST_PARTIAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                level_d = LVLW'(0);
            end
        endcase

        if (push) begin
            mem_res_d[wr_ptr_q]  = bus.in_result;
            mem_op_d[wr_ptr_q]   = bus.in_op;
            mem_zero_d[wr_ptr_q] = ~|bus.in_result;
            mem_neg_d[wr_ptr_q]  = bus.in_result[WIDTH-1];
            wr_ptr_d             = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
            cnt_d    = cnt_q + CNTW'(1);
        end

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        head_res_d  = mem_res_d[rd_ptr_d];
        head_op_d   = mem_op_d[rd_ptr_d];
        head_zero_d = mem_zero_d[rd_ptr_d];
        head_neg_d  = mem_neg_d[rd_ptr_d];
    end

    // Reset clears storage too, so the head reads as a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_res_q  <= '0;
            head_op_q   <= '0;
            head_zero_q <= 1'b1;
            head_neg_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_res_q[i]  <= '0;
                mem_op_q[i]   <= '0;
                mem_zero_q[i] <= 1'b1;
                mem_neg_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_res_q  <= head_res_d;
            head_op_q   <= head_op_d;
            head_zero_q <= head_zero_d;
            head_neg_q  <= head_neg_d;
            mem_res_q   <= mem_res_d;
            mem_op_q    <= mem_op_d;
            mem_zero_q  <= mem_zero_d;
            mem_neg_q   <= mem_neg_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = head_res_q;
    assign bus.out_op     = head_op_q;
    assign bus.out_zero   = head_zero_q;
    assign bus.out_neg    = head_neg_q;
    assign bus.level      = level_q;
    assign bus.done_cnt   = cnt_q;
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: handshake, ordering, flags, async reset and counter wrap.
module tb_alu_result_buffer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_result_buffer_if #(.WIDTH(32), .DEPTH(2), .OPW(3), .CNTW(16)) bus ();

    alu_result_buffer #(.WIDTH(32), .DEPTH(2), .OPW(3), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        step();
        step();

        // Reset values
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_op", 32'(bus.out_op), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd1);
        check("rst_out_neg", 32'(bus.out_neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // AND result 0xF0F0F0F0 & 0xFF00FF00
        bus.in_valid  = 1'b1;
        bus.in_result = 32'hF000_F000;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_out_result", bus.out_result, 32'hF000_F000);
        check("t1_out_neg", 32'(bus.out_neg), 32'd1);
        check("t1_out_zero", 32'(bus.out_zero), 32'd0);
        check("t1_level", 32'(bus.level), 32'd1);
        step();
        check("t1_done_cnt", 32'(bus.done_cnt), 32'd1);
        check("t1_empty", 32'(bus.out_valid), 32'd0);

        // Zero result with op 2
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h0000_0000;
        bus.in_op     = 3'd2;
        step();
        bus.in_valid = 1'b0;
        check("t2_out_zero", 32'(bus.out_zero), 32'd1);
        check("t2_out_neg", 32'(bus.out_neg), 32'd0);
        check("t2_out_op", 32'(bus.out_op), 32'd2);
        step();
        check("t2_done_cnt", 32'(bus.done_cnt), 32'd2);

        // Backpressure: fill, refuse third, drain in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h1111_1111;
        bus.in_op     = 3'd1;
        step();
        bus.in_result = 32'h2222_2222;
        bus.in_op     = 3'd2;
        step();
        check("t3_level_full", 32'(bus.level), 32'd2);
        check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_result = 32'h3333_3333;
        bus.in_op     = 3'd3;
        step();
        check("t3_level_hold", 32'(bus.level), 32'd2);
        check("t3_head_stable", bus.out_result, 32'h1111_1111);
        bus.out_ready = 1'b1;
        step();
        check("t3_head2", bus.out_result, 32'h2222_2222);
        check("t3_level_after_pop", 32'(bus.level), 32'd1);
        check("t3_in_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("t3_head3", bus.out_result, 32'h3333_3333);
        check("t3_head3_op", 32'(bus.out_op), 32'd3);
        check("t3_level_pushpop", 32'(bus.level), 32'd1);
        step();
        check("t3_drained", 32'(bus.out_valid), 32'd0);
        check("t3_done_cnt", 32'(bus.done_cnt), 32'd5);

        // Stream 8 results back to back
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_result = 32'hA5A5_0000 + 32'(i);
            bus.in_op     = 3'(i);
            step();
            check("t4_stream_data", bus.out_result, 32'hA5A5_0000 + 32'(i));
            check("t4_stream_level", 32'(bus.level), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check("t4_done_cnt", 32'(bus.done_cnt), 32'd13);
        check("t4_empty", 32'(bus.level), 32'd0);

        // Asynchronous reset with two entries held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h8000_0001;
        step();
        bus.in_result = 32'h0000_0002;
        step();
        bus.in_valid = 1'b0;
        check("t5_level_pre", 32'(bus.level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_level", 32'(bus.level), 32'd0);
        check("t5_done_cnt", 32'(bus.done_cnt), 32'd0);
        check("t5_out_result", bus.out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // done_cnt wrap: stream until 0xFFFF pops, then one more
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h0000_0055;
        for (int k = 0; k < 70000 && bus.done_cnt != 16'hFFFF; k++) begin
            step();
        end
        bus.in_valid = 1'b0;
        check("t6_done_max", 32'(bus.done_cnt), 32'h0000_FFFF);
        check("t6_valid_before_wrap", 32'(bus.out_valid), 32'd1);
        step();
        check("t6_done_wrap", 32'(bus.done_cnt), 32'h0000_0000);
        check("t6_empty_after", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
